// File: rtl/icache_line.sv
// icache_line: direct-mapped instruction cache with single-word refill
// through the memory controller (MC).
//
// Ports:
//   clk_in, rst_in            clock; asynchronous active-high reset
//   rdy_in                    global ready; low freezes all state
//   flush_in                  invalidate every line
//   IF_in, IFAddr_in          fetch request and byte address from IF
//   MEM_MCAccess_in           MEM stage wants the MC (has priority)
//   MC_busyMEM_in             MC currently serving MEM
//   MCinstE_in, MCinst_in     one-cycle word return strobe and data from MC
//   IF_instE_out, IF_inst_out hit indication and instruction (combinational)
//   MCE_out, MC_addr_out      registered one-cycle word request to MC
//   hitCnt_out, missCnt_out   saturating statistics counters
//
// Build option: define ICACHE_STATS_EN to implement the statistics
// counters; otherwise hitCnt_out and missCnt_out are tied to zero.

module icache_line #(
    parameter int ADDR_W     = 18,
    parameter int INDEX_BITS = 7,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              IF_in,
    input  logic [ADDR_W-1:0] IFAddr_in,
    input  logic              MEM_MCAccess_in,
    input  logic              MC_busyMEM_in,
    input  logic              MCinstE_in,
    input  logic [31:0]       MCinst_in,
    output logic              IF_instE_out,
    output logic [31:0]       IF_inst_out,
    output logic              MCE_out,
    output logic [ADDR_W-1:0] MC_addr_out,
    output logic [31:0]       hitCnt_out,
    output logic [31:0]       missCnt_out
);

    localparam int WB      = $clog2(LINE_WORDS);
    localparam int WSEL_W  = (WB > 0) ? WB : 1;
    localparam int LINES   = 1 << INDEX_BITS;
    localparam int TAG_LSB = 2 + WB + INDEX_BITS;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t state_q, state_d;

    logic [31:0]       data_mem [LINES][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_q;

    logic [ADDR_W-1:0]     base_q;
    logic [INDEX_BITS-1:0] lat_index_q;
    logic [TAG_W-1:0]      lat_tag_q;
    logic [WSEL_W-1:0]     cnt_q;

    logic [WSEL_W-1:0]     req_word;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit;
    logic                  miss, issue, fill_we, fill_last;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^IFAddr_in[1:0];

    assign req_index = IFAddr_in[2+WB +: INDEX_BITS];
    assign req_tag   = IFAddr_in[ADDR_W-1:TAG_LSB];

    generate
        if (WB > 0) begin : g_wsel
            assign req_word = IFAddr_in[2 +: WSEL_W];
        end else begin : g_no_wsel
            assign req_word = '0;
        end
    endgenerate

    assign hit = IF_in && (state_q == IDLE) && valid_q[req_index]
                 && (tag_mem[req_index] == req_tag);

    assign IF_instE_out = hit;
    assign IF_inst_out  = hit ? data_mem[req_index][req_word] : '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        miss      = 1'b0;
        issue     = 1'b0;
        fill_we   = 1'b0;
        fill_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush_in && IF_in && !hit) begin
                    miss    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (flush_in) begin
                    state_d = IDLE;
                end else if (!MEM_MCAccess_in && !MC_busyMEM_in) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A word arriving together with a flush already settles the
                // outstanding request, so skip DRAIN (it would wait forever).
                if (MCinstE_in) begin
                    fill_we = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        fill_last = !flush_in;
                        state_d   = IDLE;
                    end else begin
                        state_d = flush_in ? IDLE : REQ;
                    end
                end else if (flush_in) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (MCinstE_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q     <= '0;
            cnt_q       <= '0;
            MCE_out     <= 1'b0;
            MC_addr_out <= '0;
            base_q      <= '0;
            lat_index_q <= '0;
            lat_tag_q   <= '0;
        end else if (rdy_in) begin
            MCE_out     <= issue;
            MC_addr_out <= issue ? (base_q + ADDR_W'({cnt_q, 2'b00})) : '0;
            if (miss) begin
                base_q      <= {IFAddr_in[ADDR_W-1:2+WB], {(2 + WB){1'b0}}};
                lat_index_q <= req_index;
                lat_tag_q   <= req_tag;
                cnt_q       <= '0;
            end else if (fill_we && (cnt_q != LAST_WORD)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (flush_in) begin
                valid_q <= '0;
            end else begin
                if (miss) begin
                    valid_q[req_index] <= 1'b0;
                end
                if (fill_last) begin
                    valid_q[lat_index_q] <= 1'b1;
                end
            end
        end else begin
            MCE_out     <= 1'b0;
            MC_addr_out <= '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            data_mem[lat_index_q][cnt_q] <= MCinst_in;
        end
        if (rdy_in && fill_last) begin
            tag_mem[lat_index_q] <= lat_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_in) begin
            if (IF_instE_out && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hitCnt_out  = hit_cnt_q;
    assign missCnt_out = miss_cnt_q;
`else
    assign hitCnt_out  = '0;
    assign missCnt_out = '0;
`endif

endmodule
